// File: rtl/cntr_updn_mod.sv
// Parametrised N-bit up/down modulo counter with enable, load, clear, run-time
// modulus and registered terminal-count pulse. Optional saturation via CNTR_SAT_EN.
module cntr_updn_mod #(
  parameter int             N       = 8,
  parameter logic [N-1:0]   RST_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
`ifdef CNTR_SAT_EN
  input  logic         sat,
`endif
  input  logic         en,
  input  logic         up_dn,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] cntr_out,
  output logic         tc
);

  localparam logic [N-1:0] ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         tc_q;
  logic         tc_d;
  logic         sat_s;
  logic         at_top_s;
  logic         at_bot_s;

`ifdef CNTR_SAT_EN
  assign sat_s = sat;
`else
  assign sat_s = 1'b0;
`endif

  // An out-of-range value (above max_val) is treated as a limit in both directions.
  assign at_top_s = (cnt_q >= max_val);
  assign at_bot_s = (cnt_q == ZERO) || (cnt_q > max_val);

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = ZERO;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top_s) begin
          cnt_d = sat_s ? max_val : ZERO;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (at_bot_s) begin
          cnt_d = (sat_s && (cnt_q == ZERO)) ? ZERO : max_val;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cntr_out = cnt_q;
  assign tc       = tc_q;

endmodule

// File: tb/tb_cntr_updn_mod.sv
// Randomised self-checking bench for cntr_updn_mod (N=8, RST_VAL=0) against a
// modular-arithmetic reference model.
module tb_cntr_updn_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] max_val = 8'd255;
  logic       sat_tb = 1'b0;
  logic [7:0] cntr_out;
  logic       tc;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;
  int m_tc    = 0;

  cntr_updn_mod #(.N(8), .RST_VAL(8'd0)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef CNTR_SAT_EN
    .sat      (sat_tb),
`endif
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .cntr_out (cntr_out),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  // Reference: counting is modular over 0..max_val; values above max_val snap to the limit.
  function automatic void model_step();
    int mx = int'(max_val);
    int c  = m_cnt;
    m_tc = 0;
    if (clr) m_cnt = 0;
    else if (load) m_cnt = int'(load_val);
    else if (en && up_dn) begin
      if (c >= mx) begin
        m_tc  = 1;
        m_cnt = (sat_tb == 1'b1) ? mx : 0;
      end else m_cnt = (c + 1) % (mx + 1);
    end else if (en) begin
      if (c == 0 || c > mx) begin
        m_tc  = 1;
        m_cnt = (sat_tb == 1'b1 && c == 0) ? 0 : mx;
      end else m_cnt = (c + mx) % (mx + 1);
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (cntr_out !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d tc=%0b expected cnt=0 tc=0", cntr_out, tc);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m_cnt = 0; m_tc = 0;
  endtask

  task automatic test_up_wrap();
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    max_val = 8'd9; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++;
      if (cntr_out !== 8'(exp_seq[i]) || tc !== (exp_seq[i] == 0) || cntr_out !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0b", i, cntr_out, tc,
                 exp_seq[i], exp_seq[i] == 0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_down_wrap();
    int exp_seq[7] = '{5, 4, 3, 2, 1, 0, 5};
    clr = 1'b1; step(); clr = 1'b0;
    max_val = 8'd5; up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++;
      if (cntr_out !== 8'(exp_seq[i]) || tc !== (i == 0 || i == 6)) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0b", i, cntr_out, tc,
                 exp_seq[i], (i == 0 || i == 6));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (cntr_out !== 8'd5 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: cnt=%0d tc=%0b expected cnt=5 tc=0", i, cntr_out, tc);
      end
    end
  endtask

  task automatic test_load_oob();
    max_val = 8'd100; load_val = 8'd200;
    load = 1'b1; step(); load = 1'b0;
    n_tests++;
    if (cntr_out !== 8'd200 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_oob: cnt=%0d tc=%0b expected cnt=200 tc=0", cntr_out, tc);
    end
    en = 1'b1; up_dn = 1'b1; step(); en = 1'b0;
    n_tests++;
    if (cntr_out !== 8'd0 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_up: cnt=%0d tc=%0b expected cnt=0 tc=1", cntr_out, tc);
    end
    load = 1'b1; step(); load = 1'b0;
    en = 1'b1; up_dn = 1'b0; step(); en = 1'b0;
    n_tests++;
    if (cntr_out !== 8'd100 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_down: cnt=%0d tc=%0b expected cnt=100 tc=1", cntr_out, tc);
    end
  endtask

  task automatic test_priority();
    max_val = 8'd50; load_val = 8'd7;
    load = 1'b1; step();
    clr = 1'b1; en = 1'b1; load_val = 8'd33; step(); clr = 1'b0;
    n_tests++;
    if (cntr_out !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_prio: cnt=%0d tc=%0b expected cnt=0 tc=0", cntr_out, tc);
    end
    load_val = 8'd3; up_dn = 1'b1; step();
    n_tests++;
    if (cntr_out !== 8'd3 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_prio: cnt=%0d tc=%0b expected cnt=3 tc=0", cntr_out, tc);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    max_val = 8'd255; load_val = 8'h40;
    load = 1'b1; step(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1; step(); step();
    n_tests++;
    if (cntr_out !== 8'h42) begin
      n_fail++;
      $display("FAIL pre_reset: cnt=%0d expected cnt=66", cntr_out);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (cntr_out !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d tc=%0b expected cnt=0 tc=0", cntr_out, tc);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cntr_out !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: cnt=%0d tc=%0b expected cnt=0 tc=0", cntr_out, tc);
    end
    reset = 1'b1; m_cnt = 0; m_tc = 0;
    en = 1'b0;
  endtask

  task automatic test_max_zero();
    max_val = 8'd0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_dn = 1'($urandom_range(0, 1));
      step();
      n_tests++;
      if (cntr_out !== 8'd0 || tc !== 1'b1) begin
        n_fail++;
        $display("FAIL max_zero[%0d]: cnt=%0d tc=%0b expected cnt=0 tc=1", i, cntr_out, tc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 99) < 4);
      load     = ($urandom_range(0, 99) < 8);
      en       = ($urandom_range(0, 99) < 75);
      up_dn    = 1'($urandom_range(0, 1));
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0)
        max_val = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      step();
      n_tests++;
      if (cntr_out !== 8'(m_cnt) || tc !== 1'(m_tc)) begin
        n_fail++;
        $display("FAIL random[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0d", i, cntr_out, tc,
                 m_cnt, m_tc);
      end
    end
    idle_inputs();
  endtask

`ifdef CNTR_SAT_EN
  task automatic test_sat();
    int exp_up[5] = '{1, 2, 3, 3, 3};
    sat_tb = 1'b1; max_val = 8'd3;
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (cntr_out !== 8'(exp_up[i]) || tc !== (i >= 3)) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0b", i, cntr_out, tc,
                 exp_up[i], i >= 3);
      end
    end
    load_val = 8'd1; load = 1'b1; step(); load = 1'b0;
    up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (cntr_out !== 8'd0 || tc !== (i == 1)) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: cnt=%0d tc=%0b expected cnt=0 tc=%0b", i, cntr_out, tc,
                 i == 1);
      end
    end
    idle_inputs();
    test_random();
    sat_tb = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_oob();
    test_priority();
    test_async_reset();
    test_max_zero();
    test_random();
`ifdef CNTR_SAT_EN
    test_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
